aud_pcm_dsm_out: RTL and testbench
==================================

# aud_pcm_dsm_out

Audio output stage that consumes the 8-bit signed left/right PCM stream produced by the FM synth and converts it into two 1-bit pin-level signals for an external RC-filtered audio jack. It sits between the synth's PCM outputs and the board's audio pins. It adds:
- a soft mute/unmute gain ramp;
- a coarse shift attenuator;
- either sigma-delta or PWM modulation, selected per mode.

## Interface
Parameters:
- TICK_INC, 16'h0290, fractional increment per clock for the sample/ramp tick (about 1 MHz at 100 MHz).
- RAMP_MAX, 16, full-scale gain; fixed, must be a power of two.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, asynchronous, active-low.
- pcmInL  in  8  left sample, signed two's complement, from synth outPcmL.
- pcmInR  in  8  right sample, signed, from synth outPcmR.
- cfgMute  in  1  1 = ramp gain to 0; 0 = ramp gain to RAMP_MAX.
- cfgVol  in  3  attenuation as an arithmetic right shift, 0..7.
- cfgMode  in  1  0 = sigma-delta; 1 = PWM.
- outAudL  out  1  left modulated output.
- outAudR  out  1  right modulated output.
- outMuted  out  1  high while gain == 0.
- outSat  out  1  1-cycle pulse on any integrator saturation.

## Operation
- **Input capture.**
  - pcmIn* is registered every clock into pcmHold*.
  - pcmHold* is copied to smp* only on tick.
- **Tick.** {tick, frac} <= {1'b0, frac} + TICK_INC, with frac 16 bits.
- **Gain ramp.** Gain is 5 bits, 0..16. On each tick it moves by ±1 toward its target (0 if cfgMute, else 16).
- **Scaling.** Per channel:
  - scaled = ((smp * gain) >>> 4) >>> cfgVol, signed, truncated to 8 bits;
  - smp*gain is 13-bit signed;
  - u = scaled ^ 8'h80, the unsigned offset form.
- **Sigma-delta, cfgMode = 0, first order.**
  - {out, acc} <= acc + u every clock, with acc 8-bit unsigned.
  - Mean output density is u/256.
- **PWM, cfgMode = 1.**
  - An 8-bit counter cnt increments every clock.
  - pwmU latches u when cnt == 255.
  - out <= (cnt < pwmU).
  - Period is 256 clocks. pwmU = 0 gives constant 0; the maximum high time is 255/256.
- **Mode change.** Takes effect next clock. The idle modulator's accumulator/counter keeps running.
- **Status.** outMuted <= (gain == 0), registered.

## Timing
- **Reset values.** On reset assertion, immediately (async):
  - outAudL = outAudR = 0, outMuted = 1, outSat = 0;
  - gain = 0, frac = 0, acc = 0, cnt = 0;
  - integrators = 0, smp = 0, pwmU = 8'h80.
- **Sample latency.** A pcmIn change reaches smp 1 clock plus up to one tick period later, and the modulator output 1 clock after that.
- **Ramp timing.** After reset release with cfgMute = 0, gain reaches 16 after 16 ticks. outMuted falls 1 clock after the first tick.
- **Mute timing.** cfgMute 0→1 at full gain: gain reaches 0 on the 16th tick; outMuted rises 1 clock later.
- **Mid-ramp reversal.** Toggling cfgMute mid-ramp reverses direction from the current gain; there is no restart.
- **Simultaneous events.** A tick coinciding with cnt == 255: pwmU latches u computed from the pre-tick smp/gain.
- **Wrap-around.** frac, acc and cnt wrap modulo 2^n. Gain saturates at 0 and 16.
- **Saturation.** Worst case (smp = -128, gain = 16, cfgVol = 0) gives scaled = -128 exactly; there is no overflow.

## Configuration
- **AUD_DSM_ORDER2_EN defined.** The sigma-delta path is second order, per channel:
  - x = scaled (signed);
  - fb = prevOut ? +128 : -128;
  - i1 <= sat12(i1 + x - fb);
  - i2 <= sat14(i2 + i1 - fb);
  - out <= (i2 >= 0).
  - outSat pulses for 1 clock whenever sat12 or sat14 clamps (±2047 / ±8191).
- **AUD_DSM_ORDER2_EN undefined.** First-order path as above; outSat is tied to 0. PWM is unaffected in both builds.

## Test plan
- Reset release with pcmIn = 8'h00, cfgMute = 0, cfgVol = 0, mode 0 (first order) → outMuted falls after the first tick; after 16 ticks, any 256-clock window holds 128 ones on each output.
- pcmInL = 8'h7F, full gain, mode 0 → 255 ones per 256 clocks on outAudL; outAudR follows its own pcmInR.
- Mode 1, pcmInL = 8'hC0 (u = 8'h40), full gain → outAudL high exactly for cnt 0..63 of every 256-clock period, starting the period after the latch.
- cfgVol = 2, pcmInL = 8'h40 → u = 8'h90: 144 ones/256 (mode 0) or 144-clock high pulse (mode 1).
- cfgMute 0→1 at full gain → outMuted rises 1 clock after the 16th tick; output density then 128/256 (mode 0). cfgMute back to 0 after 8 ticks → gain climbs from 8, with no jump.
- reset asserted mid-PWM-period, no clock edge → outAudL/R = 0 and outMuted = 1 combinationally. After release, cnt restarts at 0 and the ramp restarts from gain 0.

Source files
------------

// File: rtl/aud_pcm_dsm_out.sv
// Audio output stage: soft mute ramp, shift attenuator, sigma-delta or PWM pin modulation.
// Build option AUD_DSM_ORDER2_EN: second-order saturating sigma-delta with outSat reporting.
module aud_pcm_dsm_out #(
    parameter logic [15:0] TICK_INC = 16'h0290,
    parameter int unsigned RAMP_MAX = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] pcmInL,
    input  logic [7:0] pcmInR,
    input  logic       cfgMute,
    input  logic [2:0] cfgVol,
    input  logic       cfgMode,
    output logic       outAudL,
    output logic       outAudR,
    output logic       outMuted,
    output logic       outSat
);
    localparam int unsigned GS = $clog2(RAMP_MAX);
    localparam int unsigned GW = GS + 1;
    localparam int unsigned PW = 8 + GW;

    logic [7:0]    hold [2];
    logic [7:0]    smp  [2];
    logic [15:0]   frac;
    logic          tick;
    logic [GW-1:0] gain;
    logic [GW-1:0] gain_next;
    logic [7:0]    cnt;
    logic [7:0]    pwm_u    [2];
    logic [7:0]    scaled   [2];
    logic [7:0]    u        [2];
    logic          pwm_bit  [2];
    logic          dsm_next [2];
`ifdef AUD_DSM_ORDER2_EN
    logic signed [7:0]  x       [2];
    logic signed [8:0]  fb      [2];
    logic signed [12:0] i1_sum  [2];
    logic signed [14:0] i2_sum  [2];
    logic signed [11:0] i1      [2];
    logic signed [11:0] i1_next [2];
    logic signed [13:0] i2      [2];
    logic signed [13:0] i2_next [2];
    logic               dsm     [2];
    logic               sat_any;
`else
    logic [7:0] acc      [2];
    logic [7:0] acc_next [2];
`endif

    // Gain-scaled, attenuated sample; the product always fits, so truncation is lossless.
    function automatic logic [7:0] scale(input logic [7:0] s, input logic [GW-1:0] g,
                                         input logic [2:0] vol);
        logic signed [PW-1:0] p;
        p = $signed({{GW{s[7]}}, s}) * $signed({8'b0, g});
        p = (p >>> GS) >>> vol;
        return 8'(p);
    endfunction

    // Ramp step toward the mute target, saturating at both ends.
    always_comb begin : ramp_step
        gain_next = gain;
        if (cfgMute) begin
            if (gain != '0) gain_next = gain - GW'(1);
        end else if (gain != GW'(RAMP_MAX)) begin
            gain_next = gain + GW'(1);
        end
    end

    // Sample capture, tick generation, gain ramp and mute status.
    always_ff @(posedge clock or negedge reset) begin : capture
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                hold[c] <= 8'h00;
                smp[c]  <= 8'h00;
            end
            frac     <= 16'h0000;
            tick     <= 1'b0;
            gain     <= '0;
            outMuted <= 1'b1;
        end else begin
            hold[0] <= pcmInL;
            hold[1] <= pcmInR;
            {tick, frac} <= {1'b0, frac} + {1'b0, TICK_INC};
            if (tick) begin
                for (int c = 0; c < 2; c++) smp[c] <= hold[c];
                gain <= gain_next;
            end
            outMuted <= (gain == '0);
        end
    end

    // Per-channel scaling and next-state of both modulators.
    always_comb begin : modulate
`ifdef AUD_DSM_ORDER2_EN
        sat_any = 1'b0;
`endif
        for (int c = 0; c < 2; c++) begin
            scaled[c]  = scale(smp[c], gain, cfgVol);
            u[c]       = scaled[c] ^ 8'h80;
            pwm_bit[c] = (cnt < pwm_u[c]);
`ifdef AUD_DSM_ORDER2_EN
            x[c]      = $signed(scaled[c]);
            fb[c]     = dsm[c] ? 9'sd128 : -9'sd128;
            i1_sum[c] = 13'(i1[c]) + 13'(x[c]) - 13'(fb[c]);
            i2_sum[c] = 15'(i2[c]) + 15'(i1[c]) - 15'(fb[c]);
            if (i1_sum[c] > 13'sd2047) begin
                i1_next[c] = 12'sd2047;
                sat_any    = 1'b1;
            end else if (i1_sum[c] < -13'sd2047) begin
                i1_next[c] = -12'sd2047;
                sat_any    = 1'b1;
            end else begin
                i1_next[c] = 12'(i1_sum[c]);
            end
            if (i2_sum[c] > 15'sd8191) begin
                i2_next[c] = 14'sd8191;
                sat_any    = 1'b1;
            end else if (i2_sum[c] < -15'sd8191) begin
                i2_next[c] = -14'sd8191;
                sat_any    = 1'b1;
            end else begin
                i2_next[c] = 14'(i2_sum[c]);
            end
            dsm_next[c] = ~i2[c][13];
`else
            {dsm_next[c], acc_next[c]} = {1'b0, acc[c]} + {1'b0, u[c]};
`endif
        end
    end

    // Both modulators always run; cfgMode only picks which one drives the pins.
    always_ff @(posedge clock or negedge reset) begin : modulators
        if (!reset) begin
            cnt     <= 8'h00;
            outAudL <= 1'b0;
            outAudR <= 1'b0;
            outSat  <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                pwm_u[c] <= 8'h80;
`ifdef AUD_DSM_ORDER2_EN
                i1[c]  <= '0;
                i2[c]  <= '0;
                dsm[c] <= 1'b0;
`else
                acc[c] <= 8'h00;
`endif
            end
        end else begin
            cnt <= cnt + 8'd1;
            for (int c = 0; c < 2; c++) begin
                if (cnt == 8'hFF) pwm_u[c] <= u[c];
`ifdef AUD_DSM_ORDER2_EN
                i1[c]  <= i1_next[c];
                i2[c]  <= i2_next[c];
                dsm[c] <= dsm_next[c];
`else
                acc[c] <= acc_next[c];
`endif
            end
            outAudL <= cfgMode ? pwm_bit[0] : dsm_next[0];
            outAudR <= cfgMode ? pwm_bit[1] : dsm_next[1];
`ifdef AUD_DSM_ORDER2_EN
            outSat <= sat_any;
`else
            outSat <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_aud_pcm_dsm_out.sv
// Self-checking bench for aud_pcm_dsm_out (default first-order build): densities, PWM phase, ramp timing.
module tb_aud_pcm_dsm_out;
    localparam longint TINC = 656;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] pcmInL = 8'h00;
    logic [7:0] pcmInR = 8'h00;
    logic       cfgMute = 1'b0;
    logic [2:0] cfgVol = 3'd0;
    logic       cfgMode = 1'b0;
    logic       outAudL, outAudR, outMuted, outSat;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    aud_pcm_dsm_out dut (
        .clock(clock), .reset(reset),
        .pcmInL(pcmInL), .pcmInR(pcmInR),
        .cfgMute(cfgMute), .cfgVol(cfgVol), .cfgMode(cfgMode),
        .outAudL(outAudL), .outAudR(outAudR), .outMuted(outMuted), .outSat(outSat)
    );

    // Reference: k clocks since reset; a tick is flagged whenever k*TICK_INC crosses a multiple of 2^16.
    longint k;
    logic   tick_d;
    int     m_gain;
    logic   m_muted;

    function automatic logic tick_at(longint n);
        return ((n * TINC) >> 16) != (((n - 1) * TINC) >> 16);
    endfunction

    function automatic int floordiv(int a, int d);
        return (a >= 0) ? a / d : -((-a + d - 1) / d);
    endfunction

    // Expected offset code at full gain: floor(pcm*16/16) then floor(/2^vol), re-biased by 128.
    function automatic int exp_u(logic [7:0] pcm, int g, int vol);
        int q;
        q = floordiv(int'($signed(pcm)) * g, 16);
        q = floordiv(q, 1 << vol);
        return (q & 255) ^ 128;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            k       <= 0;
            tick_d  <= 1'b0;
            m_gain  <= 0;
            m_muted <= 1'b1;
        end else begin
            k       <= k + 1;
            tick_d  <= tick_at(k + 1);
            if (tick_d) m_gain <= cfgMute ? ((m_gain > 0) ? m_gain - 1 : 0)
                                          : ((m_gain < 16) ? m_gain + 1 : 16);
            m_muted <= (m_gain == 0);
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic window(output int nl, output int nr);
        nl = 0;
        nr = 0;
        repeat (256) begin
            @(negedge clock);
            nl += int'(outAudL);
            nr += int'(outAudR);
        end
    endtask

    task automatic check_ramp_start(string tag);
        int kf;
        kf = 1;
        while (!tick_at(kf)) kf++;
        for (int i = 1; i <= kf + 2; i++) begin
            @(negedge clock);
            if (i == kf + 1) chk({tag, "_muted_hold"}, 32'(outMuted), 1);
            if (i == kf + 2) chk({tag, "_muted_fall"}, 32'(outMuted), 0);
        end
    endtask

    task automatic check_pwm_phase(string tag, int ul, int ur);
        int bad;
        bad = 0;
        repeat (256) begin
            @(negedge clock);
            if (outAudL !== (((k - 1) % 256) < ul)) bad++;
            if (outAudR !== (((k - 1) % 256) < ur)) bad++;
        end
        chk(tag, 32'(bad), 0);
    endtask

    task automatic density(string tag, int el, int er);
        int nl, nr;
        window(nl, nr);
        chk({tag, "_L"}, 32'(nl), 32'(el));
        chk({tag, "_R"}, 32'(nr), 32'(er));
    endtask

    initial begin
        int nt, idx16, bad, ones;
        bit done;

        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_audL", 32'(outAudL), 0);
        chk("rst_audR", 32'(outAudR), 0);
        chk("rst_muted", 32'(outMuted), 1);
        chk("rst_sat", 32'(outSat), 0);

        @(negedge clock);
        reset = 1'b1;
        check_ramp_start("ramp");
        idle(1700);
        density("zero_dsm", 128, 128);
        chk("sat_idle", 32'(outSat), 0);

        pcmInL = 8'h7F;
        pcmInR = 8'($urandom_range(0, 255));
        idle(600);
        density("full_dsm", 255, exp_u(pcmInR, 16, 0));

        cfgMode = 1'b1;
        pcmInL  = 8'hC0;
        pcmInR  = 8'($urandom_range(0, 255));
        idle(600);
        check_pwm_phase("pwm_phase", 64, exp_u(pcmInR, 16, 0));

        cfgVol = 3'd2;
        pcmInL = 8'h40;
        idle(600);
        density("vol2_pwm", 144, exp_u(pcmInR, 16, 2));
        cfgMode = 1'b0;
        idle(20);
        density("vol2_dsm", 144, exp_u(pcmInR, 16, 2));

        for (int it = 0; it < 6; it++) begin
            pcmInL  = 8'($urandom_range(0, 255));
            pcmInR  = 8'($urandom_range(0, 255));
            cfgVol  = 3'($urandom_range(0, 7));
            cfgMode = 1'($urandom_range(0, 1));
            idle(600);
            density(cfgMode ? "rand_pwm" : "rand_dsm",
                    exp_u(pcmInL, 16, int'(cfgVol)), exp_u(pcmInR, 16, int'(cfgVol)));
        end

        // Full-gain mute: outMuted must rise two samples after the 16th tick flag.
        cfgMode = 1'b0;
        cfgVol  = 3'd0;
        pcmInL  = 8'h7F;
        pcmInR  = 8'h81;
        idle(600);
        cfgMute = 1'b1;
        nt = 0; idx16 = -1; bad = 0; done = 1'b0;
        for (int i = 0; i < 2500 && !done; i++) begin
            if (idx16 >= 0 && i == idx16 + 1) chk("mute_pre_rise", 32'(outMuted), 0);
            if (idx16 >= 0 && i == idx16 + 2) begin
                chk("mute_rise", 32'(outMuted), 1);
                done = 1'b1;
            end
            if (tick_d && idx16 < 0) begin
                nt++;
                if (nt == 16) idx16 = i;
            end
            if (outMuted !== m_muted) bad++;
            @(negedge clock);
        end
        chk("mute_done", 32'(done), 1);
        chk("mute_track", 32'(bad), 0);
        idle(600);
        density("muted_dsm", 128, 128);

        // Reversal after 8 down-steps: gain climbs back from 8 and never touches 0.
        cfgMute = 1'b0;
        idle(1800);
        cfgMute = 1'b1;
        nt = 0;
        for (int i = 0; i < 2000 && nt < 8; i++) begin
            if (tick_d) nt++;
            @(negedge clock);
        end
        chk("rev_ticks", 32'(nt), 8);
        cfgMute = 1'b0;
        ones = 0;
        repeat (1000) begin
            @(negedge clock);
            ones += int'(outMuted);
        end
        chk("rev_no_mute", 32'(ones), 0);
        idle(800);
        density("rev_full", 255, exp_u(8'h81, 16, 0));

        // Asynchronous reset mid-PWM-period, then ramp and counter restart.
        cfgMode = 1'b1;
        idle(600);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("midrst_audL", 32'(outAudL), 0);
        chk("midrst_audR", 32'(outAudR), 0);
        chk("midrst_muted", 32'(outMuted), 1);
        pcmInL = 8'hC0;
        pcmInR = 8'($urandom_range(0, 255));
        @(negedge clock);
        reset = 1'b1;
        check_ramp_start("reramp");
        idle(1900);
        check_pwm_phase("repwm_phase", 64, exp_u(pcmInR, 16, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
